// File: rtl/mips_multicycle_seq_pkg.sv
// Shared types and constants for the multi-cycle MIPS sequencer.
//   state_e    : sequencer state encoding (also driven on the state port)
//   mem_bus_t  : registered memory request payload
//   OP_*       : instruction opcodes the sequencer distinguishes
package mips_multicycle_seq_pkg;

  localparam int unsigned XLEN = 32;
  localparam int unsigned OP_W = 6;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_LOAD   = 3'd5,
    S_ERR    = 3'd6
  } state_e;

  typedef struct packed {
    logic            req;
    logic            wr;
    logic [XLEN-1:0] addr;
    logic [XLEN-1:0] wdata;
  } mem_bus_t;

  localparam logic [OP_W-1:0] OP_RTYPE = 6'h00;
  localparam logic [OP_W-1:0] OP_J     = 6'h02;
  localparam logic [OP_W-1:0] OP_BEQ   = 6'h04;
  localparam logic [OP_W-1:0] OP_ADDI  = 6'h08;
  localparam logic [OP_W-1:0] OP_ADDIU = 6'h09;
  localparam logic [OP_W-1:0] OP_SLTI  = 6'h0a;
  localparam logic [OP_W-1:0] OP_ANDI  = 6'h0c;
  localparam logic [OP_W-1:0] OP_ORI   = 6'h0d;
  localparam logic [OP_W-1:0] OP_LW    = 6'h23;
  localparam logic [OP_W-1:0] OP_SW    = 6'h2b;

  // Opcodes whose result comes from the external ALU and is written back.
  function automatic logic is_alu_op(input logic [OP_W-1:0] op);
    return (op == OP_RTYPE) || (op == OP_ADDI) || (op == OP_ADDIU) ||
           (op == OP_SLTI)  || (op == OP_ANDI) || (op == OP_ORI);
  endfunction

endpackage

// File: rtl/mips_multicycle_seq_mem_wait_timer.sv
// Memory wait timer: counts cycles while a request is outstanding and
// flags expiry on the TIMEOUT-th cycle without an acknowledge.
//   clk, rst   : clock, async active-high reset
//   en_i       : request outstanding
//   ack_i      : acknowledge sampled this cycle
//   expire_c_o : combinational expiry flag (this is the TIMEOUT-th wait cycle)
module mem_wait_timer #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic en_i,
  input  logic ack_i,
  output logic expire_c_o
);

  localparam int unsigned CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign expire_c_o = en_i && (cnt_q == CW'(TIMEOUT - 1));

  // Restart for every new request; an ack or expiry ends the current one.
  always_comb begin
    cnt_d = cnt_q;
    if (!en_i || ack_i || expire_c_o) cnt_d = '0;
    else                              cnt_d = cnt_q + CW'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/mips_multicycle_seq.sv
// Multi-cycle MIPS sequencer: owns PC, IR and writeback data, and steps each
// instruction through FETCH/DECODE/EXEC/MEM/WB over one shared req/ack memory
// port. Also streams instruction words into memory in load mode (WE/W_Ins).
//   CLK, RST                     : clock, async active-high reset
//   WE, W_Ins                    : load-mode request and word to store
//   mem_req/wr/addr/wdata        : registered memory request, held until ack
//   mem_rdata, mem_ack           : memory response
//   Result, Rdata2               : external ALU result and rt register data
//   branch_taken, branch_target  : external beq decision, valid in EXEC
//   PC, Ins, Wdata, reg_we       : program counter, IR, writeback data/strobe
//   state, err, retired          : state encoding, sticky timeout, retire count
module mips_multicycle_seq import mips_multicycle_seq_pkg::*; #(
  parameter logic [31:0] PC_RESET = 32'h0000_0000,
  parameter int unsigned TIMEOUT  = 16,
  parameter int unsigned CNT_W    = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             WE,
  input  logic [31:0]      W_Ins,
  output logic             mem_req,
  output logic             mem_wr,
  output logic [31:0]      mem_addr,
  output logic [31:0]      mem_wdata,
  input  logic [31:0]      mem_rdata,
  input  logic             mem_ack,
  input  logic [31:0]      Result,
  input  logic [31:0]      Rdata2,
  input  logic             branch_taken,
  input  logic [31:0]      branch_target,
  output logic [31:0]      PC,
  output logic [31:0]      Ins,
  output logic [31:0]      Wdata,
  output logic             reg_we,
  output logic [2:0]       state,
  output logic             err,
  output logic [CNT_W-1:0] retired
);

  state_e           state_q, state_d;
  mem_bus_t         mem_q, mem_d;
  logic [31:0]      pc_q, pc_d;
  logic [31:0]      ir_q, ir_d;
  logic [31:0]      wdata_q, wdata_d;   // MDR for lw, captured Result otherwise
  logic [31:0]      ld_addr_q, ld_addr_d;
  logic             reg_we_q, reg_we_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] retired_q, retired_d;

  logic             expire_c;
  logic             done_c;
  logic             retire_c;
  logic [5:0]       op_c;

  mem_wait_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk        (CLK),
    .rst        (RST),
    .en_i       (mem_q.req),
    .ack_i      (mem_ack),
    .expire_c_o (expire_c)
  );

  // Timeout outranks a same-cycle ack; an ack without a request is ignored.
  assign done_c = mem_q.req && mem_ack && !expire_c;
  assign op_c   = ir_q[31:26];

  // Next-state and datapath register updates.
  always_comb begin
    state_d   = state_q;
    mem_d     = mem_q;
    pc_d      = pc_q;
    ir_d      = ir_q;
    wdata_d   = wdata_q;
    ld_addr_d = ld_addr_q;
    reg_we_d  = 1'b0;
    err_d     = err_q;
    retired_d = retired_q;
    retire_c  = 1'b0;

    if (mem_q.req && (expire_c || mem_ack)) mem_d.req = 1'b0;

    case (state_q)
      S_FETCH: begin
        if (!mem_q.req) begin
          if (WE) begin
            state_d   = S_LOAD;
            ld_addr_d = PC_RESET;
          end else begin
            mem_d = '{req: 1'b1, wr: 1'b0, addr: pc_q, wdata: 32'h0};
          end
        end else if (done_c) begin
          ir_d    = mem_rdata;
          pc_d    = pc_q + 32'd4;
          state_d = S_DECODE;
        end
      end
      S_DECODE: state_d = S_EXEC;
      S_EXEC: begin
        case (op_c)
          OP_BEQ: begin
            if (branch_taken) pc_d = branch_target;
            retire_c = 1'b1;
            state_d  = S_FETCH;
          end
          OP_J: begin
            pc_d     = {pc_q[31:28], ir_q[25:0], 2'b00};
            retire_c = 1'b1;
            state_d  = S_FETCH;
          end
          OP_LW, OP_SW: state_d = S_MEM;
          default: begin
            if (is_alu_op(op_c)) begin
              wdata_d  = Result;
              reg_we_d = 1'b1;
              state_d  = S_WB;
            end else begin
              retire_c = 1'b1;
              state_d  = S_FETCH;
            end
          end
        endcase
      end
      S_MEM: begin
        if (!mem_q.req) begin
          mem_d = '{req: 1'b1, wr: (op_c == OP_SW), addr: Result, wdata: Rdata2};
        end else if (done_c) begin
          if (op_c == OP_SW) begin
            retire_c = 1'b1;
            state_d  = S_FETCH;
          end else begin
            wdata_d  = mem_rdata;
            reg_we_d = 1'b1;
            state_d  = S_WB;
          end
        end
      end
      S_WB: begin
        retire_c = 1'b1;
        state_d  = S_FETCH;
      end
      S_LOAD: begin
        // WE is only looked at between requests, so a falling WE lets the
        // outstanding write complete first.
        if (!mem_q.req) begin
          if (WE) begin
            mem_d = '{req: 1'b1, wr: 1'b1, addr: ld_addr_q, wdata: W_Ins};
          end else begin
            pc_d    = PC_RESET;
            err_d   = 1'b0;
            state_d = S_FETCH;
          end
        end else if (done_c) begin
          ld_addr_d = ld_addr_q + 32'd4;
        end
      end
      S_ERR: begin
        if (WE) begin
          state_d   = S_LOAD;
          ld_addr_d = PC_RESET;
        end
      end
      default: state_d = S_FETCH;
    endcase

    if (mem_q.req && expire_c) begin
      err_d   = 1'b1;
      state_d = S_ERR;
    end

    if (retire_c) retired_d = retired_q + CNT_W'(1);
  end

  // State and datapath registers.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q   <= S_FETCH;
      mem_q     <= '0;
      pc_q      <= PC_RESET;
      ir_q      <= '0;
      wdata_q   <= '0;
      ld_addr_q <= PC_RESET;
      reg_we_q  <= 1'b0;
      err_q     <= 1'b0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      mem_q     <= mem_d;
      pc_q      <= pc_d;
      ir_q      <= ir_d;
      wdata_q   <= wdata_d;
      ld_addr_q <= ld_addr_d;
      reg_we_q  <= reg_we_d;
      err_q     <= err_d;
      retired_q <= retired_d;
    end
  end

  assign mem_req   = mem_q.req;
  assign mem_wr    = mem_q.wr;
  assign mem_addr  = mem_q.addr;
  assign mem_wdata = mem_q.wdata;
  assign PC        = pc_q;
  assign Ins       = ir_q;
  assign Wdata     = wdata_q;
  assign reg_we    = reg_we_q;
  assign state     = state_q;
  assign err       = err_q;
  assign retired   = retired_q;

endmodule

// File: tb/tb_mips_multicycle_seq.sv
// Bench for mips_multicycle_seq: timeout, load-mode program download, random
// program execution against an instruction-level model, and mid-wait reset.
module tb_mips_multicycle_seq;

  localparam int unsigned N_PROG  = 64;
  localparam int unsigned N_INSTR = 150;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        WE = 1'b0;
  logic [31:0] W_Ins = 32'h0;
  logic        mem_req, mem_wr;
  logic [31:0] mem_addr, mem_wdata;
  logic [31:0] mem_rdata = 32'h0;
  logic        mem_ack = 1'b0;
  logic [31:0] Result, Rdata2, branch_target;
  logic        branch_taken;
  logic [31:0] PC, Ins, Wdata;
  logic        reg_we, err;
  logic [2:0]  state;
  logic [15:0] retired;

  mips_multicycle_seq #(.PC_RESET(32'h0), .TIMEOUT(16), .CNT_W(16)) dut (
    .CLK(CLK), .RST(RST), .WE(WE), .W_Ins(W_Ins),
    .mem_req(mem_req), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .Result(Result), .Rdata2(Rdata2),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .PC(PC), .Ins(Ins), .Wdata(Wdata), .reg_we(reg_we),
    .state(state), .err(err), .retired(retired)
  );

  always #5 CLK = ~CLK;

  // Stand-in for the external register file / ALU: simple functions of Ins.
  assign Result        = {16'h0, Ins[15:0]};
  assign Rdata2        = ~Ins;
  assign branch_taken  = Ins[0];
  assign branch_target = {16'h0, Ins[15:2], 2'b00};

  typedef struct {
    bit          is_mem;
    bit          wr;
    logic [31:0] addr;
    logic [31:0] data;
    int unsigned ret;
  } ev_t;

  ev_t         sb[$];
  logic [31:0] sim_mem   [logic [31:0]];
  logic [31:0] model_mem [logic [31:0]];
  logic [31:0] prog [N_PROG];
  logic [5:0]  ops [11] = '{6'h00, 6'h02, 6'h04, 6'h23, 6'h2b, 6'h08,
                            6'h09, 6'h0a, 6'h0c, 6'h0d, 6'h3f};

  int          n_cmp = 0;
  int          n_bad = 0;
  bit          checking = 1'b0;
  bit          hold_rd = 1'b0;
  int          rsp_mode = 1;   // 0 random latency, 1 never ack, 2 ack stuck high
  int          lat = -1;
  int          acks_done = 0;
  logic [31:0] cap_addr, cap_wdata;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %08h expected %08h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] rd_sim(input logic [31:0] a);
    return sim_mem.exists(a) ? sim_mem[a] : 32'h0;
  endfunction

  function automatic logic [31:0] rd_model(input logic [31:0] a);
    return model_mem.exists(a) ? model_mem[a] : 32'h0;
  endfunction

  function automatic void push_ev(input bit m, input bit w, input logic [31:0] a,
                                  input logic [31:0] d, input int unsigned r);
    sb.push_back('{is_mem: m, wr: w, addr: a, data: d, ret: r});
  endfunction

  // Instruction-level model: walks the program and lists the bus and
  // register-write events it must produce, in order.
  task automatic run_model();
    logic [31:0] pc, ins, res;
    int unsigned ret;
    pc  = 32'h0;
    ret = 0;
    for (int i = 0; i < N_INSTR; i++) begin
      ins = rd_model(pc);
      push_ev(1'b1, 1'b0, pc, 32'h0, 0);
      pc  = pc + 32'd4;
      res = {16'h0, ins[15:0]};
      case (ins[31:26])
        6'h04: if (ins[0]) pc = {16'h0, ins[15:2], 2'b00};
        6'h02: pc = {pc[31:28], ins[25:0], 2'b00};
        6'h23: begin
          push_ev(1'b1, 1'b0, res, 32'h0, 0);
          push_ev(1'b0, 1'b0, 32'h0, rd_model(res), ret);
        end
        6'h2b: begin
          push_ev(1'b1, 1'b1, res, ~ins, 0);
          model_mem[res] = ~ins;
        end
        6'h00, 6'h08, 6'h09, 6'h0a, 6'h0c, 6'h0d: push_ev(1'b0, 1'b0, 32'h0, res, ret);
        default: ;
      endcase
      ret++;
    end
  endtask

  task automatic sb_mem();
    ev_t e;
    if (sb.size() == 0) begin
      n_cmp++; n_bad++;
      $display("FAIL mem_txn: got request at %08h, expected no request", mem_addr);
      return;
    end
    e = sb.pop_front();
    if (!e.is_mem) begin
      n_cmp++; n_bad++;
      $display("FAIL mem_txn: got request at %08h, expected reg write %08h", mem_addr, e.data);
      return;
    end
    chk("mem_addr", mem_addr, e.addr);
    chk("mem_wr", 32'(mem_wr), 32'(e.wr));
    if (e.wr) chk("mem_wdata", mem_wdata, e.data);
  endtask

  task automatic sb_reg();
    ev_t e;
    if (sb.size() == 0) begin
      n_cmp++; n_bad++;
      $display("FAIL reg_write: got Wdata %08h, expected no write", Wdata);
      return;
    end
    e = sb.pop_front();
    if (e.is_mem) begin
      n_cmp++; n_bad++;
      $display("FAIL reg_write: got Wdata %08h, expected request at %08h", Wdata, e.addr);
      return;
    end
    chk("wb_data", Wdata, e.data);
    chk("wb_retired", 32'(retired), e.ret);
    chk("wb_state", 32'(state), 32'd4);
  endtask

  // Memory responder plus monitor; everything happens on the falling edge.
  always @(negedge CLK) begin
    if (rsp_mode == 2) begin
      mem_ack = 1'b1;
      lat     = -1;
    end else if (mem_ack) begin
      mem_ack = 1'b0;
      lat     = -1;
    end else if (rsp_mode == 0 && mem_req) begin
      if (lat < 0) begin
        lat       = (hold_rd && !mem_wr) ? 1000 : int'($urandom_range(0, 6));
        cap_addr  = mem_addr;
        cap_wdata = mem_wdata;
      end else if (checking) begin
        chk("addr_stable", mem_addr, cap_addr);
        chk("wdata_stable", mem_wdata, cap_wdata);
      end
      if (lat == 0) begin
        if (checking) sb_mem();
        if (mem_wr) sim_mem[mem_addr] = mem_wdata;
        else        mem_rdata = rd_sim(mem_addr);
        mem_ack = 1'b1;
        acks_done++;
      end else begin
        lat--;
      end
    end else begin
      lat = -1;
    end
    if (checking && reg_we) sb_reg();
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt, g, base;
    logic [31:0] w;
    logic [5:0]  op;

    // Random program in 0x000-0x0FC, data in 0x1000-0x10FC.
    for (int i = 0; i < N_PROG; i++) begin
      op = ops[$urandom_range(0, 10)];
      w  = $urandom;
      w[31:26] = op;
      case (op)
        6'h23, 6'h2b: w[15:0] = 16'h1000 + 16'($urandom_range(0, 63) * 4);
        6'h04:        w[15:0] = 16'($urandom_range(0, 63) * 4) | 16'($urandom_range(0, 1));
        6'h02:        w[25:0] = 26'($urandom_range(0, 63));
        default: ;
      endcase
      prog[i] = w;
      model_mem[32'(i * 4)] = w;
    end
    for (int i = 0; i < 64; i++) begin
      w = $urandom;
      sim_mem[32'h1000 + 32'(i * 4)]   = w;
      model_mem[32'h1000 + 32'(i * 4)] = w;
    end

    // Reset values.
    repeat (3) @(negedge CLK);
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    chk("rst_mem_wr", 32'(mem_wr), 32'd0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_mem_wdata", mem_wdata, 32'h0);
    chk("rst_pc", PC, 32'h0);
    chk("rst_ins", Ins, 32'h0);
    chk("rst_reg_we", 32'(reg_we), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_retired", 32'(retired), 32'd0);
    chk("rst_state", 32'(state), 32'd0);
    RST = 1'b0;

    // No ack ever: request must give up after 16 cycles.
    cnt = 0;
    for (int c = 0; c < 100; c++) begin
      @(negedge CLK);
      if (mem_req) cnt++;
      else if (cnt > 0) break;
    end
    chk("timeout_req_cycles", 32'(cnt), 32'd16);
    chk("timeout_err", 32'(err), 32'd1);
    chk("timeout_state", 32'(state), 32'd6);
    chk("timeout_mem_req", 32'(mem_req), 32'd0);
    chk("timeout_pc", PC, 32'h0);

    // Download the program through load mode, then run it.
    for (int i = 0; i < N_PROG; i++) push_ev(1'b1, 1'b1, 32'(i * 4), prog[i], 0);
    run_model();
    rsp_mode = 0;
    checking = 1'b1;
    base     = acks_done;
    WE       = 1'b1;
    W_Ins    = prog[0];
    for (int i = 0; i < N_PROG; i++) begin
      g = 0;
      while (acks_done <= base + i && g < 200) begin
        @(posedge CLK);
        g++;
      end
      if (g >= 200) begin
        n_cmp++; n_bad++;
        $display("FAIL load_ack: word %0d got no ack within 200 cycles", i);
        break;
      end
      #1;
      if (i + 1 < N_PROG) W_Ins = prog[i + 1];
      else                WE = 1'b0;
    end
    @(posedge CLK); #1;
    chk("load_exit_err", 32'(err), 32'd0);
    chk("load_exit_pc", PC, 32'h0);
    chk("load_exit_state", 32'(state), 32'd0);

    for (int c = 0; c < 20000 && sb.size() > 0; c++) @(posedge CLK);
    n_cmp++;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d events still pending, expected 0", sb.size());
    end
    checking = 1'b0;
    chk("run_err", 32'(err), 32'd0);

    // Reset in the middle of a read wait; stale ack afterwards is ignored.
    hold_rd = 1'b1;
    g = 0;
    while (lat <= 100 && g < 500) begin
      @(posedge CLK); #1;
      g++;
    end
    chk("hold_found", 32'(lat > 100), 32'd1);
    repeat (2) @(posedge CLK);
    #2 RST = 1'b1;
    #1;
    chk("arst_mem_req", 32'(mem_req), 32'd0);
    chk("arst_mem_addr", mem_addr, 32'h0);
    chk("arst_pc", PC, 32'h0);
    chk("arst_ins", Ins, 32'h0);
    chk("arst_retired", 32'(retired), 32'd0);
    chk("arst_state", 32'(state), 32'd0);
    @(negedge CLK);
    rsp_mode = 2;
    repeat (2) @(negedge CLK);
    RST     = 1'b0;
    hold_rd = 1'b0;
    @(posedge CLK); #1;
    rsp_mode = 0;
    @(negedge CLK);
    chk("post_rst_req", 32'(mem_req), 32'd1);
    chk("post_rst_addr", mem_addr, 32'h0);
    chk("post_rst_wr", 32'(mem_wr), 32'd0);
    @(negedge CLK);
    chk("stale_ack_req_held", 32'(mem_req), 32'd1);
    chk("stale_ack_state", 32'(state), 32'd0);
    chk("stale_ack_pc", PC, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mips_multicycle_seq.md
Name: mips_multicycle_seq

Overview:
Multi-cycle successor to the single-cycle MIPS top. It sequences one instruction over FETCH/DECODE/EXEC/MEM/WB states through a single shared memory port with req/ack handshake and variable latency. It also provides the instruction-load mode (WE/W_Ins) as a sequenced memory write stream, a wait-timeout error and a retired-instruction counter. The existing register file and ALU stay outside; this block owns PC, IR, MDR and all control timing.

Parameters:
PC_RESET, 32'h0000_0000, PC value after reset and after a load session; also the first load address.
TIMEOUT, 16, maximum cycles mem_req may wait for mem_ack before error (≥2).
CNT_W, 16, width of the retired-instruction counter.

Ports:
CLK  in  1  clock, rising edge.
RST  in  1  reset, asynchronous, active-high.
WE  in  1  load mode request.
W_Ins  in  32  instruction word to write in load mode.
mem_req  out  1  memory request.
mem_wr  out  1  1 = write, 0 = read; valid with mem_req.
mem_addr  out  32  byte address; valid with mem_req.
mem_wdata  out  32  write data; valid with mem_req.
mem_rdata  in  32  read data; valid in the cycle mem_ack=1.
mem_ack  in  1  request completed this cycle.
Result  in  32  external ALU result (EX address/data).
Rdata2  in  32  register rt data, used as store data.
branch_taken  in  1  external beq compare result, valid in EXEC.
branch_target  in  32  external branch target, valid in EXEC.
PC  out  32  program counter.
Ins  out  32  instruction register.
Wdata  out  32  writeback data: MDR for lw, Result otherwise.
reg_we  out  1  register-file write strobe, 1 cycle.
state  out  3  current state encoding.
err  out  1  sticky timeout error.
retired  out  CNT_W  completed instruction count, wraps.

Behaviour:
- Reset values: PC=PC_RESET, Ins=0, MDR=0, mem_req=0, mem_wr=0, mem_addr=0, mem_wdata=0, reg_we=0, err=0, retired=0, state=FETCH (idle, no request).
- RST mid-transaction: mem_req drops immediately. A later mem_ack with mem_req=0 is ignored.
- Handshake:
  - mem_req/mem_wr/mem_addr/mem_wdata are registered and held stable until mem_ack=1 is sampled.
  - mem_req is 0 on the cycle after ack; at least one idle cycle between requests.
  - mem_ack while mem_req=0 is ignored.
- Timeout: a wait counter runs while mem_req=1. After TIMEOUT cycles without ack:
  - mem_req drops, err goes to 1, state goes to ERR.
  - ERR holds until RST or WE=1.
- States:
  - FETCH:
    - If WE=1 and no request is outstanding, go to LOAD.
    - Otherwise issue a read at PC.
    - On ack: Ins<=mem_rdata, PC<=PC+4, go to DECODE.
  - DECODE: 1 cycle, then EXEC.
  - EXEC: 1 cycle; opcode Ins[31:26] decides:
    - beq: PC<=branch_target if branch_taken; retire; go to FETCH.
    - j: PC<={PC[31:28],Ins[25:0],2'b00}; retire; go to FETCH.
    - lw/sw: go to MEM.
    - R-type and ALU immediates (addi/addiu/andi/ori/slti): go to WB.
    - Any other opcode: NOP; retire; go to FETCH.
  - MEM:
    - Issue a request at Result; sw uses mem_wr=1, mem_wdata=Rdata2.
    - On ack, sw: retire, go to FETCH.
    - On ack, lw: MDR<=mem_rdata, go to WB.
  - WB: reg_we=1 for exactly this cycle; Wdata valid; retire; go to FETCH.
  - LOAD:
    - Load address starts at PC_RESET.
    - While WE=1: issue a write of W_Ins, sampled at request issue. On ack, load address +=4; issue the next request after the idle gap.
    - WE=0 with no request outstanding: PC<=PC_RESET, err<=0, go to FETCH.
    - WE falling mid-request: the request completes first.
  - ERR: WE=1 goes to LOAD; otherwise stay.
- Retire: retired<=retired+1, modulo 2^CNT_W.
- PC+4 wraps modulo 2^32.
- Priority: RST > timeout > ack > WE.

Decomposition:
- Opcode constants (OP_RTYPE=6'h00, OP_J=6'h02, OP_BEQ=6'h04, OP_LW=6'h23, OP_SW=6'h2b, ALU-immediate opcodes) and state encodings go in common_param.vh:
  - S_FETCH=0, S_DECODE=1, S_EXEC=2, S_MEM=3, S_WB=4, S_LOAD=5, S_ERR=6.
- One sub-module, mem_wait_timer: counts while enabled, clears on ack/idle, pulses expire at TIMEOUT.

Test Plan:
- Zero-latency ack, addi then sw to 0x40 → sw issues mem_wr=1, addr 0x40, wdata=Rdata2; PC=0x8; retired=2; reg_we pulsed once, in WB of addi only.
- lw with ack delayed 5 cycles, rdata 0xDEADBEEF → mem_req held 6 cycles, addr/wdata stable; Wdata=0xDEADBEEF with reg_we=1 exactly one cycle.
- beq taken, target 0x100 → next fetch addr 0x100. Not taken → 0x4. j with Ins[25:0]=0x40 → next fetch addr 0x100.
- Ack never arrives, TIMEOUT=16 → err=1 and state=ERR after 16 request cycles; mem_req=0. Then WE=1 → LOAD; WE=0 after load → err=0, PC=PC_RESET.
- Load three words 0x11, 0x22, 0x33 → writes at 0x0, 0x4, 0x8 with matching data; then fetch from 0x0.
- RST asserted mid-lw wait, ack arrives after reset → all outputs at reset values asynchronously; stale ack ignored; fetch of 0x0 starts after release.
